// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
// Raster sequencer for a KxK sliding window fed one pixel per accept.
// It decides when the window and line buffers shift, tracks the raster position,
// and flags each complete in-image patch with its top-left coordinate in the
// output map.
module conv_window_sequencer #(
   parameter int unsigned IMG_WIDTH  = 28,
   parameter int unsigned IMG_HEIGHT = 28,
   parameter int unsigned K          = 7
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_start,
   input  logic                          i_pixel_valid,
   output logic                          o_pixel_ready,
   output logic                          o_shift_enable,
   input  logic                          i_conv_ready,
   output logic                          o_win_valid,
   output logic [$clog2(IMG_HEIGHT)-1:0] o_win_row,
   output logic [$clog2(IMG_WIDTH)-1:0]  o_win_col,
   output logic                          o_busy,
   output logic                          o_frame_done
);

   localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
   localparam int unsigned COL_W = $clog2(IMG_WIDTH);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(K - 1);
   localparam logic [COL_W-1:0] COL_EDGE = COL_W'(K - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t             r_state;
   logic [ROW_W-1:0]   r_row;
   logic [COL_W-1:0]   r_col;
   logic               r_win_valid;
   logic [ROW_W-1:0]   r_win_row;
   logic [COL_W-1:0]   r_win_col;
   logic               r_frame_done;

   logic               w_stall;
   logic               w_accept;
   logic               w_last_pix;
   logic               w_patch;
   logic               w_consume;

   // A held patch that the convolution block has not taken blocks further shifting,
   // since a shift would overwrite the window contents it still needs.
   assign w_stall        = r_win_valid && !i_conv_ready;
   assign w_consume      = r_win_valid && i_conv_ready;
   assign o_pixel_ready  = (r_state == S_RUN) && !w_stall;
   assign w_accept       = i_pixel_valid && o_pixel_ready;
   assign o_shift_enable = w_accept;

   // Position of the pixel being accepted this cycle
   assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);
   // Only full in-image windows count. Left-edge columns are excluded because
   // they still hold stale pixels from the previous row.
   assign w_patch    = (r_row >= ROW_EDGE) && (r_col >= COL_EDGE);

   assign o_busy       = (r_state != S_IDLE);
   assign o_win_valid  = r_win_valid;
   assign o_win_row    = r_win_row;
   assign o_win_col    = r_win_col;
   assign o_frame_done = r_frame_done;

   // Frame FSM, raster counters and the end-of-frame pulse
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_row        <= '0;
         r_col        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state <= S_RUN;
                  r_row   <= '0;
                  r_col   <= '0;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  if (r_col == COL_LAST) begin
                     r_col <= '0;
                     r_row <= r_row + ROW_W'(1);
                  end else begin
                     r_col <= r_col + COL_W'(1);
                  end
                  if (w_last_pix) begin
                     r_state <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               // Leave once the final patch is gone, either already or this cycle
               if (!r_win_valid || w_consume) begin
                  r_state      <= S_IDLE;
                  r_frame_done <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Patch flag and coordinates: set on a patch-completing shift, cleared when consumed
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_win_valid <= 1'b0;
         r_win_row   <= '0;
         r_win_col   <= '0;
      end else if (w_accept && w_patch) begin
         // Also covers consume-and-replace in the same cycle, so there is no bubble
         r_win_valid <= 1'b1;
         r_win_row   <= r_row - ROW_EDGE;
         r_win_col   <= r_col - COL_EDGE;
      end else if (w_consume) begin
         r_win_valid <= 1'b0;
      end
   end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Controls the 7x7 pixel window shift register: decides when it shifts, tracks raster position, and flags when the window holds a complete in-image patch for the convolution block.
- Sits between the UART pixel source / line buffers and the window plus multiplier array.
- Provides a valid/ready pixel intake, drives the shared shift enable for the line buffers and window, and applies backpressure from the convolution block.

Parameters:
- IMG_WIDTH, 28, pixels per image row (must be >= K).
- IMG_HEIGHT, 28, rows per frame (must be >= K).
- K, 7, window edge length.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  one-cycle pulse that begins a frame; ignored unless idle.
- pixel_valid  in  1  UART pixel byte available.
- pixel_ready  out  1  sequencer accepts the pixel this cycle.
- shift_enable  out  1  shift strobe to the window and line buffers; equals pixel_valid && pixel_ready.
- conv_ready  in  1  convolution block consumes the current window.
- win_valid  out  1  window contents form a complete patch.
- win_row  out  $clog2(IMG_HEIGHT)  output-map row of the valid patch (top-left corner).
- win_col  out  $clog2(IMG_WIDTH)  output-map column of the valid patch.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when the final patch is consumed.

Behaviour:
- Reset (rst high at clk edge): state IDLE; col=0, row=0; win_valid=0, win_row=0, win_col=0, frame_done=0. This forces pixel_ready=0, shift_enable=0, busy=0. Reset mid-frame aborts immediately with no frame_done.
- States: IDLE, RUN, FLUSH.
  - IDLE -> RUN on start; col and row cleared on entry.
  - RUN -> FLUSH when the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
  - FLUSH -> IDLE when win_valid is 0, or win_valid && conv_ready (final patch consumed). frame_done pulses in the cycle after that transition.
- busy is 1 in RUN and FLUSH.
- pixel_ready = (state==RUN) && !(win_valid && !conv_ready). It is combinational and never depends on pixel_valid.
- Acceptance: an accept occurs when pixel_valid && pixel_ready. shift_enable is high in exactly those cycles. One pixel is accepted per accept cycle.
- Position counters advance on each accept:
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - row does not wrap within a frame; it is cleared on IDLE -> RUN.
- Window valid:
  - On an accept at (row, col) with row >= K-1 and col >= K-1: win_valid <= 1 next cycle, win_row <= row-(K-1), win_col <= col-(K-1).
  - Otherwise, if win_valid && conv_ready: win_valid <= 0.
  - Latency: 1 cycle from accept to win_valid. The patch reflects the window state after that shift.
- Left-edge patches (col < K-1) are never flagged, because stale columns from the previous row are still in the window.
- Backpressure: while win_valid && !conv_ready, no accept occurs. win_valid, win_row and win_col hold stable.
- Same-cycle consume and replace: win_valid && conv_ready together with an accept that produces a new patch keeps win_valid=1 with updated coordinates. No bubble cycle is required.
- start during RUN or FLUSH is ignored. pixel_valid outside RUN is ignored (pixel_ready=0).
- Patch count per frame: (IMG_HEIGHT-K+1)*(IMG_WIDTH-K+1), in raster order.
- Arithmetic: unsigned counters; coordinate subtraction is performed only under the guard above, so it never underflows.

Test Plan:
- Reset/idle: assert rst, then hold pixel_valid=1 with no start -> pixel_ready=0, shift_enable=0, win_valid=0, busy=0 for 10 cycles.
- Full frame, no stall: IMG_WIDTH=IMG_HEIGHT=8, K=3, start, pixel_valid=1 and conv_ready=1 continuously.
  - Exactly 36 win_valid cycles.
  - First patch (0,0) appears 1 cycle after the 19th accept.
  - Last patch is (5,5).
  - frame_done pulses once; busy falls after 64 accepts plus flush.
- Backpressure: same config, drop conv_ready for 5 cycles when patch (2,3) is valid -> win_valid stays 1, coords stay (2,3), shift_enable=0 throughout; resumes with (2,4) when conv_ready returns.
- Row wrap: accepts at col 7 row 2, then col 0 row 3 -> patch (0,5) flagged; no patch flagged for cols 0..1 of row 3; next patch is (1,0) after the col 2 accept.
- Sparse input: pixel_valid toggling 1/0 every cycle -> identical patch sequence to the no-stall run; shift_enable only in valid cycles.
- Abort/ignore: start pulsed mid-frame has no effect; rst asserted after 30 accepts returns to IDLE with no frame_done; a new start then yields first patch (0,0) after 19 accepts.
